// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle MIPS-style control FSM with memory wait timeout
//   Ports:
//     clk, reset (async, active-high)
//     op[5:0]      opcode from the instruction register
//     mem_ready    memory finishes the current access this cycle
//     PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite   enables
//     IorD, RegDst, MemToReg, AluSrcA, AluSrcB[1:0], PCSource[1:0], AluOp[2:0]   selects
//     state[3:0], illegal_op, error, instr_count[15:0]   status
module unidad_control_multiciclo #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IorD,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        AluSrcA,
    output logic [1:0]  AluSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  AluOp,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic        error,
    output logic [15:0] instr_count
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_ERROR     = 4'd15;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    logic [3:0]  r_state;
    logic [7:0]  r_wait;
    logic [15:0] r_instr_count;
    logic [3:0]  w_next;
    logic        w_waiting;
    logic        w_timeout;
    logic        w_retire;
    // Only the three memory-facing states can stall on mem_ready
    assign w_waiting = (r_state == S_FETCH || r_state == S_MEM_READ || r_state == S_MEM_WRITE) && !mem_ready;
    // Widened compare so a full 8-bit counter can never wrap past the limit
    assign w_timeout = w_waiting && ({1'b0, r_wait} + 9'd1 == 9'(MEM_TIMEOUT));
    assign w_retire  = (w_next == S_FETCH) &&
                       (r_state inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB});
    assign state       = r_state;
    assign instr_count = r_instr_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_wait        <= 8'd0;
            r_instr_count <= 16'd0;
        end else begin
            r_state       <= w_next;
            r_wait        <= w_waiting ? r_wait + 8'd1 : 8'd0;
            r_instr_count <= w_retire ? r_instr_count + 16'd1 : r_instr_count;
        end
    end
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (op)
                    OP_R:         w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default:      w_next = S_FETCH;
                endcase
            S_MEM_ADDR:  w_next = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_next = S_R_WB;
            S_ADDI_EX:   w_next = S_ADDI_WB;
            S_ERROR:     w_next = S_ERROR;
            default:     w_next = S_FETCH;
        endcase
        if (w_timeout)
            w_next = S_ERROR;
    end
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        PCSource    = 2'b00;
        AluOp       = 3'b000;
        illegal_op  = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                AluSrcB    = 2'b11;
                illegal_op = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEM_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                AluSrcA = 1'b1;
                AluOp   = 3'b001;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA     = 1'b1;
                AluOp       = 3'b010;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_EX: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_ERROR:   error = 1'b1;
            default: ;
        endcase
        // Reset is asynchronous, so state already reads FETCH; keep its enables quiet too
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            illegal_op  = 1'b0;
        end
    end
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: random and directed checks against a path-based control model
module tb_unidad_control_multiciclo;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite;
    logic IorD, RegDst, MemToReg, AluSrcA, illegal_op, error;
    logic [1:0] AluSrcB, PCSource;
    logic [2:0] AluOp;
    logic [3:0] state;
    logic [15:0] instr_count;
    logic [18:0] dut_ctrl;
    int n_chk = 0;
    int n_pass = 0;
    logic [3:0] m_state = 4'd0;
    int m_wait = 0;
    logic [15:0] m_cnt = 16'd0;
    logic [3:0] m_path[$];
    unidad_control_multiciclo #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .PCSource(PCSource), .AluOp(AluOp),
        .state(state), .illegal_op(illegal_op), .error(error), .instr_count(instr_count)
    );
    always #5 clk = ~clk;
    assign dut_ctrl = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
                       IorD, RegDst, MemToReg, AluSrcA, AluSrcB, PCSource, AluOp, illegal_op, error};
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask
    // What each state must drive, straight from the state descriptions
    function automatic logic [18:0] exp_out(input logic [3:0] s, input logic [5:0] o, input logic mr, input logic rst);
        logic pcw = 0, pcc = 0, irw = 0, mrd = 0, mwr = 0, rw = 0;
        logic iod = 0, rd = 0, m2r = 0, asa = 0, ill = 0, err = 0;
        logic [1:0] asb = 0, pcs = 0;
        logic [2:0] aop = 0;
        case (s)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin asb = 2'b11; ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000}); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mwr = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 3'b001; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 3'b010; pcc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd15: err = 1;
            default: ;
        endcase
        if (rst) {pcw, pcc, irw, mwr, rw, ill} = 6'd0;
        return {pcw, pcc, irw, mrd, mwr, rw, iod, rd, m2r, asa, asb, pcs, aop, ill, err};
    endfunction
    task automatic model_reset();
        m_state = 4'd0;
        m_wait = 0;
        m_cnt = 16'd0;
        m_path.delete();
    endtask
    // Instruction is a list of states chosen at DECODE (refined at MEM_ADDR); running out retires it
    task automatic model_step();
        if (reset) model_reset();
        else if (m_state == 4'd15) ;
        else if (m_state inside {4'd0, 4'd3, 4'd5} && !mem_ready) begin
            m_wait++;
            if (m_wait == TO) begin m_state = 4'd15; m_wait = 0; end
        end else begin
            m_wait = 0;
            if (m_state == 4'd0) m_state = 4'd1;
            else if (m_state == 4'd1) begin
                m_path.delete();
                case (op)
                    6'b000000: m_path = '{4'd6, 4'd7};
                    6'b100011, 6'b101011: m_path = '{4'd2};
                    6'b000100: m_path = '{4'd8};
                    6'b000010: m_path = '{4'd9};
                    6'b001000: m_path = '{4'd10, 4'd11};
                    default: ;
                endcase
                m_state = (m_path.size() > 0) ? m_path.pop_front() : 4'd0;
            end else if (m_state == 4'd2) begin
                if (op == 6'b100011) m_path = '{4'd3, 4'd4};
                else m_path = '{4'd5};
                m_state = m_path.pop_front();
            end else if (m_path.size() == 0) begin
                m_state = 4'd0;
                m_cnt++;
            end else m_state = m_path.pop_front();
        end
    endtask
    task automatic tick(input logic [5:0] o, input logic mr);
        op = o;
        mem_ready = mr;
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick(6'd0, 1'b0);
        tick(6'd0, 1'b0);
        reset = 1'b0;
    endtask
    always @(negedge clk) begin
        check("ctrl", 32'(dut_ctrl), 32'(exp_out(m_state, op, mem_ready, reset)));
        check("state", 32'(state), 32'(m_state));
        check("instr_count", 32'(instr_count), 32'(m_cnt));
    end
    initial begin
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        mem_ready = 1'b1;
        #1;
        check("reset_pcwrite", 32'(PCWrite), 32'd0);
        check("reset_irwrite", 32'(IRWrite), 32'd0);
        do_reset();
        check("reset_state", 32'(state), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        tick(6'b000000, 1'b1); check("r_s1", 32'(state), 32'd1);
        tick(6'b000000, 1'b1); check("r_s2", 32'(state), 32'd6);
        tick(6'b000000, 1'b1); check("r_s3", 32'(state), 32'd7);
        check("r_regwrite", 32'(RegWrite), 32'd1);
        check("r_regdst", 32'(RegDst), 32'd1);
        tick(6'b000000, 1'b1); check("r_s4", 32'(state), 32'd0);
        check("r_count", 32'(instr_count), 32'd1);
        tick(6'b100011, 1'b1); tick(6'b100011, 1'b1); tick(6'b100011, 1'b1);
        check("lw_memread", 32'(state), 32'd3);
        repeat (3) tick(6'b100011, 1'b0);
        check("lw_wait", 32'(state), 32'd3);
        tick(6'b100011, 1'b1); check("lw_wb", 32'(state), 32'd4);
        check("lw_memtoreg", 32'(MemToReg), 32'd1);
        tick(6'b100011, 1'b1); check("lw_done", 32'(state), 32'd0);
        tick(6'b111111, 1'b1); check("ill_state", 32'(state), 32'd1);
        check("ill_flag", 32'(illegal_op), 32'd1);
        check("ill_enables", 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
        tick(6'b111111, 1'b1); check("ill_next", 32'(state), 32'd0);
        check("ill_count", 32'(instr_count), 32'd2);
        do_reset();
        tick(6'b000100, 1'b1); tick(6'b000100, 1'b1);
        check("beq_state", 32'(state), 32'd8);
        check("beq_ctrl", 32'({PCWriteCond, PCSource, AluOp}), 32'({1'b1, 2'b01, 3'b010}));
        tick(6'b000010, 1'b1); tick(6'b000010, 1'b1); tick(6'b000010, 1'b1);
        check("j_state", 32'(state), 32'd9);
        check("j_ctrl", 32'({PCWrite, PCSource}), 32'({1'b1, 2'b10}));
        tick(6'b000010, 1'b1); check("bj_count", 32'(instr_count), 32'd2);
        tick(6'b101011, 1'b1); tick(6'b101011, 1'b1); tick(6'b101011, 1'b0);
        check("sw_memwrite", 32'(MemWrite), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_count", 32'(instr_count), 32'd0);
        tick(6'd0, 1'b0);
        reset = 1'b0;
        repeat (3) tick(6'd0, 1'b0);
        check("to_pre", 32'(state), 32'd0);
        tick(6'd0, 1'b0);
        check("to_state", 32'(state), 32'd15);
        check("to_error", 32'(error), 32'd1);
        tick(6'd0, 1'b1); tick(6'd0, 1'b1);
        check("to_hold", 32'(state), 32'd15);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                model_reset();
            end else reset = 1'b0;
            tick(($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)],
                 $urandom_range(0, 9) < 7);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
